// File: rtl/cricket_pkg.sv
// Shared constants for the T20 delivery tracker: display modes, display FSM states, extra codes.
// Latency: n/a (constants only); backpressure: n/a.
package cricket_pkg;

  localparam logic [1:0] MODE_BALLS      = 2'd0;
  localparam logic [1:0] MODE_OVER_BAR   = 2'd1;
  localparam logic [1:0] MODE_OVERS_BALL = 2'd2;
  localparam logic [1:0] MODE_EXTRAS     = 2'd3;

  localparam logic [1:0] ST_SHOW   = 2'd0;
  localparam logic [1:0] ST_FLASH  = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  localparam int DEF_WIDE_CODE   = 13;
  localparam int DEF_NOBALL_CODE = 14;

  localparam int EXT_W = 8;

endpackage

// File: rtl/delivery_tracker_innings_counter.sv
// One team's innings state: legal balls, overs, ball-in-over, saturating extras, closed flag.
// Latency: updates on the edge that samples hit/close; no backpressure, deliveries ignored once closed.
module innings_counter
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int BALL_W         = 7,
  parameter int OVER_W         = 5,
  parameter int BIO_W          = 3
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              hit,
  input  logic              legal,
  input  logic              close,
  output logic [BALL_W-1:0] balls,
  output logic [OVER_W-1:0] overs,
  output logic [BIO_W-1:0]  bio,
  output logic [EXT_W-1:0]  extras,
  output logic              done,
  output logic              over_done
);

  logic [BALL_W-1:0] balls_q, balls_d;
  logic [OVER_W-1:0] overs_q, overs_d;
  logic [BIO_W-1:0]  bio_q, bio_d;
  logic [EXT_W-1:0]  extras_q, extras_d;
  logic              done_q, done_d;
  logic              count_vld;
  logic              last_ball;
  logic              last_over;

  assign count_vld = hit & ~done_q;
  assign last_ball = (bio_q == BIO_W'(BALLS_PER_OVER - 1));
  assign last_over = (overs_q == OVER_W'(MAX_OVERS - 1));
  assign over_done = count_vld & legal & last_ball;

  always_comb begin
    balls_d  = balls_q;
    overs_d  = overs_q;
    bio_d    = bio_q;
    extras_d = extras_q;
    done_d   = done_q;
    if (count_vld) begin
      if (legal) begin
        balls_d = balls_q + BALL_W'(1);
        if (last_ball) begin
          bio_d   = '0;
          overs_d = overs_q + OVER_W'(1);
          // closing here keeps the counters pinned at their innings maxima
          if (last_over) begin
            done_d = 1'b1;
          end
        end else begin
          bio_d = bio_q + BIO_W'(1);
        end
      end else if (extras_q != '1) begin
        extras_d = extras_q + EXT_W'(1);
      end
    end
    // the delivery on the same edge is already counted above
    if (close) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      balls_q  <= '0;
      overs_q  <= '0;
      bio_q    <= '0;
      extras_q <= '0;
      done_q   <= 1'b0;
    end else begin
      balls_q  <= balls_d;
      overs_q  <= overs_d;
      bio_q    <= bio_d;
      extras_q <= extras_d;
      done_q   <= done_d;
    end
  end

  assign balls  = balls_q;
  assign overs  = overs_q;
  assign bio    = bio_q;
  assign extras = extras_q;
  assign done   = done_q;

endmodule

// File: rtl/delivery_tracker.sv
// Delivery/over tracker for the T20 game: per-team counters plus a registered LED display FSM.
// Latency: counters on the play edge, over_end one edge later, LEDs one edge after counters; no backpressure.
module delivery_tracker
  import cricket_pkg::*;
#(
  parameter int NUM_TEAMS      = 2,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int CODE_W         = 4,
  parameter int WIDE_CODE      = DEF_WIDE_CODE,
  parameter int NOBALL_CODE    = DEF_NOBALL_CODE,
  parameter int LED_W          = 16,
  parameter int FLASH_CYC      = 8,
  localparam int TEAM_W  = $clog2(NUM_TEAMS),
  localparam int BALL_W  = $clog2(BALLS_PER_OVER * MAX_OVERS + 1),
  localparam int OVER_W  = $clog2(MAX_OVERS + 1),
  localparam int BIO_W   = $clog2(BALLS_PER_OVER),
  localparam int FLASH_W = $clog2(FLASH_CYC + 1)
) (
  input  logic                        clk_fpga,
  input  logic                        reset,
  input  logic [TEAM_W-1:0]           team_sel,
  input  logic                        play,
  input  logic [CODE_W-1:0]           lfsr_out,
  input  logic                        inning_end,
  input  logic                        game_over,
  input  logic [LED_W-1:0]            scroll,
  input  logic [1:0]                  disp_mode,
  output logic [LED_W-1:0]            leds,
  output logic [NUM_TEAMS*BALL_W-1:0] team_balls,
  output logic [NUM_TEAMS*OVER_W-1:0] team_overs,
  output logic [NUM_TEAMS-1:0]        inning_done,
  output logic                        over_end
);

  logic                 legal;
  logic [NUM_TEAMS-1:0] sel;
  logic [NUM_TEAMS-1:0] hit;
  logic [NUM_TEAMS-1:0] close;
  logic [NUM_TEAMS-1:0] over_done;
  logic [NUM_TEAMS-1:0] done;

  logic [BALL_W-1:0] balls_a  [NUM_TEAMS];
  logic [OVER_W-1:0] overs_a  [NUM_TEAMS];
  logic [BIO_W-1:0]  bio_a    [NUM_TEAMS];
  logic [EXT_W-1:0]  extras_a [NUM_TEAMS];

  assign legal = ~((lfsr_out == CODE_W'(WIDE_CODE)) || (lfsr_out == CODE_W'(NOBALL_CODE)));

  for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
    assign sel[t]   = (team_sel == TEAM_W'(t));
    assign hit[t]   = play & ~game_over & sel[t];
    assign close[t] = inning_end & ~game_over & sel[t];

    innings_counter #(
      .BALLS_PER_OVER (BALLS_PER_OVER),
      .MAX_OVERS      (MAX_OVERS),
      .BALL_W         (BALL_W),
      .OVER_W         (OVER_W),
      .BIO_W          (BIO_W)
    ) u_cnt (
      .clk_fpga  (clk_fpga),
      .reset     (reset),
      .hit       (hit[t]),
      .legal     (legal),
      .close     (close[t]),
      .balls     (balls_a[t]),
      .overs     (overs_a[t]),
      .bio       (bio_a[t]),
      .extras    (extras_a[t]),
      .done      (done[t]),
      .over_done (over_done[t])
    );

    assign team_balls[t*BALL_W +: BALL_W] = balls_a[t];
    assign team_overs[t*OVER_W +: OVER_W] = overs_a[t];
  end

  assign inning_done = done;

  // Selected-team view for the display; an unmatched team_sel leaves it at zero.
  logic              team_ok;
  logic [BALL_W-1:0] sel_balls;
  logic [OVER_W-1:0] sel_overs;
  logic [BIO_W-1:0]  sel_bio;
  logic [EXT_W-1:0]  sel_extras;

  always_comb begin
    team_ok    = 1'b0;
    sel_balls  = '0;
    sel_overs  = '0;
    sel_bio    = '0;
    sel_extras = '0;
    for (int t = 0; t < NUM_TEAMS; t++) begin
      if (sel[t]) begin
        team_ok    = 1'b1;
        sel_balls  = balls_a[t];
        sel_overs  = overs_a[t];
        sel_bio    = bio_a[t];
        sel_extras = extras_a[t];
      end
    end
  end

  logic [LED_W-1:0] show_val;

  always_comb begin
    show_val = '0;
    case (disp_mode)
      MODE_BALLS:      show_val = LED_W'(sel_balls);
      MODE_OVER_BAR: begin
        for (int i = 0; i < LED_W; i++) begin
          show_val[i] = (i < int'(sel_bio));
        end
      end
      MODE_OVERS_BALL: show_val = LED_W'({sel_overs, sel_bio});
      default:         show_val = LED_W'(sel_extras);
    endcase
    if (!team_ok) begin
      show_val = '0;
    end
  end

  // Over completion is registered twice so over_end lands one edge after the counters move.
  logic ov_evt_q, ov_evt_d;
  logic over_end_q, over_end_d;

  always_comb begin
    ov_evt_d   = |over_done;
    over_end_d = ov_evt_q;
  end

  logic [1:0]         state_q, state_d;
  logic [FLASH_W-1:0] timer_q, timer_d;
  logic [LED_W-1:0]   leds_q, leds_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    leds_d  = show_val;
    if (game_over) begin
      state_d = ST_SCROLL;
      leds_d  = scroll;
    end else if (over_end_q) begin
      state_d = ST_FLASH;
      timer_d = FLASH_W'(FLASH_CYC - 1);
      leds_d  = '1;
    end else begin
      case (state_q)
        ST_FLASH: begin
          if (timer_q != '0) begin
            timer_d = timer_q - FLASH_W'(1);
            leds_d  = '1;
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: state_d = ST_SHOW;
      endcase
    end
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      ov_evt_q   <= 1'b0;
      over_end_q <= 1'b0;
      state_q    <= ST_SHOW;
      timer_q    <= '0;
      leds_q     <= '0;
    end else begin
      ov_evt_q   <= ov_evt_d;
      over_end_q <= over_end_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      leds_q     <= leds_d;
    end
  end

  assign leds     = leds_q;
  assign over_end = over_end_q;

endmodule

// File: tb/tb_delivery_tracker.sv
// Bench for delivery_tracker: vector table, over_end scoreboard against a reference model, corner sequences.
module tb_delivery_tracker;

  localparam int BALL_W = 7;
  localparam int OVER_W = 5;

  logic                clk_fpga = 1'b0;
  logic                reset;
  logic [0:0]          team_sel;
  logic                play;
  logic [3:0]          lfsr_out;
  logic                inning_end;
  logic                game_over;
  logic [15:0]         scroll;
  logic [1:0]          disp_mode;
  logic [15:0]         leds;
  logic [2*BALL_W-1:0] team_balls;
  logic [2*OVER_W-1:0] team_overs;
  logic [1:0]          inning_done;
  logic                over_end;

  delivery_tracker dut (
    .clk_fpga    (clk_fpga),
    .reset       (reset),
    .team_sel    (team_sel),
    .play        (play),
    .lfsr_out    (lfsr_out),
    .inning_end  (inning_end),
    .game_over   (game_over),
    .scroll      (scroll),
    .disp_mode   (disp_mode),
    .leds        (leds),
    .team_balls  (team_balls),
    .team_overs  (team_overs),
    .inning_done (inning_done),
    .over_end    (over_end)
  );

  always #5 clk_fpga = ~clk_fpga;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  int m_balls[2];
  int m_bio[2];
  int m_overs[2];
  int m_ext[2];
  bit m_done[2];

  always @(posedge clk_fpga) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_balls(input int t);
    return 32'(team_balls[t*BALL_W +: BALL_W]);
  endfunction

  function automatic logic [31:0] dut_overs(input int t);
    return 32'(team_overs[t*OVER_W +: OVER_W]);
  endfunction

  // over_end scoreboard: every expected pulse cycle must be matched exactly once.
  always @(negedge clk_fpga) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL over_end_missing: no pulse seen, expected at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (over_end === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL over_end_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          chk("over_end_cycle", cyc, exp_q.pop_front());
        end
      end
    end
  end

  task automatic model_clear();
    for (int t = 0; t < 2; t++) begin
      m_balls[t] = 0; m_bio[t] = 0; m_overs[t] = 0; m_ext[t] = 0; m_done[t] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic check_model(input string tag);
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("%s_balls%0d", tag, t), dut_balls(t), m_balls[t]);
      chk($sformatf("%s_overs%0d", tag, t), dut_overs(t), m_overs[t]);
      chk($sformatf("%s_done%0d", tag, t), 32'(inning_done[t]), 32'(m_done[t]));
    end
  endtask

  task automatic step(input logic p, input logic [3:0] code, input logic [0:0] team,
                      input logic ie, input logic go, input logic [1:0] mode, input logic [15:0] scr);
    int t;
    play = p; lfsr_out = code; team_sel = team; inning_end = ie;
    game_over = go; disp_mode = mode; scroll = scr;
    t = int'(team);
    if (p && !go && !m_done[t]) begin
      if (code == 4'd13 || code == 4'd14) begin
        if (m_ext[t] < 255) m_ext[t]++;
      end else begin
        m_balls[t]++;
        if (m_bio[t] == 5) begin
          m_bio[t] = 0;
          m_overs[t]++;
          exp_q.push_back(cyc + 2);
          if (m_overs[t] == 20) m_done[t] = 1'b1;
        end else begin
          m_bio[t]++;
        end
      end
    end
    if (ie && !go) m_done[t] = 1'b1;
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; inning_end = 1'b0; game_over = 1'b0;
    @(posedge clk_fpga);
    @(posedge clk_fpga);
    #1 reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic       p;
    logic [3:0] code;
    logic [0:0] team;
    logic [1:0] mode;
    int         exp_balls;
    int         exp_overs;
    int         exp_other;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ones;
    int first;
    int nonzero;

    play = 0; lfsr_out = 0; team_sel = 0; inning_end = 0;
    game_over = 0; scroll = 0; disp_mode = 0; reset = 1;
    do_reset();

    chk("rst_leds", 32'(leds), 0);
    chk("rst_balls", 32'(team_balls), 0);
    chk("rst_overs", 32'(team_overs), 0);
    chk("rst_done", 32'(inning_done), 0);
    chk("rst_over_end", 32'(over_end), 0);

    // T1: seven legal balls on team 0, flash after the over, then ball count
    for (int i = 0; i < 7; i++) step(1, 4'd1, 0, 0, 0, 2'd0, 16'h0);
    n_ones = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 4'd0, 0, 0, 0, 2'd0, 16'h0);
      if (leds === 16'hFFFF) begin
        n_ones++;
        if (first < 0) first = i;
      end
    end
    chk("t1_flash_len", n_ones, 8);
    chk("t1_flash_start", first, 0);
    chk("t1_leds_after", 32'(leds), 7);
    chk("t1_balls0", dut_balls(0), 7);
    chk("t1_overs0", dut_overs(0), 1);
    check_model("t1");

    // T2: extras, display modes and team isolation
    vecs[0]  = '{1'b1, 4'd13, 1'b1, 2'd3, 0, 0, 7, 16'd1};
    vecs[1]  = '{1'b1, 4'd14, 1'b1, 2'd3, 0, 0, 7, 16'd2};
    vecs[2]  = '{1'b1, 4'd3,  1'b1, 2'd3, 1, 0, 7, 16'd2};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 2'd1, 1, 0, 7, 16'h0001};
    vecs[4]  = '{1'b0, 4'd0,  1'b1, 2'd0, 1, 0, 7, 16'd1};
    vecs[5]  = '{1'b0, 4'd0,  1'b1, 2'd2, 1, 0, 7, 16'd1};
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 2'd2, 7, 1, 1, 16'd9};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 2'd1, 7, 1, 1, 16'h0001};
    vecs[8]  = '{1'b1, 4'd0,  1'b0, 2'd1, 8, 1, 1, 16'h0003};
    vecs[9]  = '{1'b1, 4'd15, 1'b0, 2'd3, 9, 1, 1, 16'd0};
    vecs[10] = '{1'b1, 4'd13, 1'b0, 2'd1, 9, 1, 1, 16'h0007};
    vecs[11] = '{1'b0, 4'd0,  1'b0, 2'd0, 9, 1, 1, 16'd9};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].p, vecs[i].code, vecs[i].team, 0, 0, vecs[i].mode, 16'h0);
      step(0, 4'd0, vecs[i].team, 0, 0, vecs[i].mode, 16'h0);
      chk($sformatf("t2_v%0d_balls", i), dut_balls(int'(vecs[i].team)), vecs[i].exp_balls);
      chk($sformatf("t2_v%0d_overs", i), dut_overs(int'(vecs[i].team)), vecs[i].exp_overs);
      chk($sformatf("t2_v%0d_other", i), dut_balls(1 - int'(vecs[i].team)), vecs[i].exp_other);
      chk($sformatf("t2_v%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end
    check_model("t2");

    // T3: run team 0 to the over limit, then one more play must be ignored
    for (int i = 0; i < 111; i++) step(1, 4'd2, 0, 0, 0, 2'd0, 16'h0);
    chk("t3_balls0", dut_balls(0), 120);
    chk("t3_overs0", dut_overs(0), 20);
    chk("t3_done0", 32'(inning_done[0]), 1);
    step(1, 4'd2, 0, 0, 0, 2'd0, 16'h0);
    chk("t3_balls0_after", dut_balls(0), 120);
    for (int i = 0; i < 12; i++) step(0, 4'd0, 0, 0, 0, 2'd0, 16'h0);
    check_model("t3");

    // T5: game_over during flash on team 1
    for (int i = 0; i < 5; i++) step(1, 4'd2, 1, 0, 0, 2'd0, 16'h0);
    step(0, 4'd0, 1, 0, 0, 2'd0, 16'h0);
    step(0, 4'd0, 1, 0, 0, 2'd0, 16'h0);
    chk("t5_flash", 32'(leds), 32'hFFFF);
    step(1, 4'd2, 1, 0, 1, 2'd0, 16'hA5C3);
    chk("t5_scroll1", 32'(leds), 32'hA5C3);
    chk("t5_play_blocked", dut_balls(1), 6);
    step(0, 4'd0, 1, 0, 1, 2'd0, 16'h1234);
    chk("t5_scroll2", 32'(leds), 32'h1234);
    step(0, 4'd0, 1, 0, 0, 2'd0, 16'h0);
    chk("t5_show", 32'(leds), 6);

    // T4: play with inning_end on team 1 counts, then team 1 is closed
    step(1, 4'd5, 1, 1, 0, 2'd3, 16'h0);
    chk("t4_balls1", dut_balls(1), 7);
    chk("t4_done1", 32'(inning_done[1]), 1);
    step(1, 4'd5, 1, 0, 0, 2'd3, 16'h0);
    chk("t4_balls1_after", dut_balls(1), 7);
    step(1, 4'd13, 1, 0, 0, 2'd3, 16'h0);
    step(0, 4'd0, 1, 0, 0, 2'd3, 16'h0);
    chk("t4_extras1", 32'(leds), 2);
    check_model("t4");
    chk("scoreboard_drained", exp_q.size(), 0);

    // T6: asynchronous reset mid-over while flashing
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 4'd4, 0, 0, 0, 2'd0, 16'h0);
    chk("t6_flash_active", 32'(leds), 32'hFFFF);
    chk("t6_balls0", dut_balls(0), 10);
    play = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_leds", 32'(leds), 0);
    chk("t6_async_balls", 32'(team_balls), 0);
    chk("t6_async_overs", 32'(team_overs), 0);
    chk("t6_async_done", 32'(inning_done), 0);
    chk("t6_async_over_end", 32'(over_end), 0);
    @(posedge clk_fpga);
    @(posedge clk_fpga);
    #1 reset = 1'b0;
    model_clear();
    nonzero = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 4'd0, 0, 0, 0, 2'd0, 16'h0);
      if (leds !== 16'h0) nonzero++;
    end
    chk("t6_show_after_reset", nonzero, 0);
    check_model("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
